// File: rtl/risc_lsu.sv
// risc_lsu: load/store unit between the execute stage and the data bus.
// Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time. It drives a
// word-aligned bus beat with byte enables and returns extended load data.
// Build option: define RISC_LSU_MISALIGNED_SPLIT_EN to split word-crossing
// accesses into two beats. Without it, such accesses complete with rsp_err.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request (req_ready=1)
// BEAT0  | first (or only) bus beat outstanding
// BEAT1  | second beat of a word-crossing access (split build only)
// RESP   | one-cycle response pulse, then back to IDLE
module risc_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;

  logic              illegal_in;
  logic              cross_in;
  logic              err_in;
  logic              split_in;
  logic              last_beat;

  logic [1:0]        off;
  logic [3:0]        base_be;
  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   load_shift;
  logic [XLEN-1:0]   load_ext;

  // Decode the incoming request: illegal funct3 and word-crossing detection
  always_comb begin
    if (req_we)
      illegal_in = (req_funct3 >= 3'd3);
    else
      illegal_in = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
    cross_in = ((req_funct3[1:0] == 2'd1) && (req_addr[1:0] == 2'd3)) ||
               ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
  end

  assign off       = addr_q[1:0];
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Size mask before lane shifting: byte, half, word
  always_comb begin
    case (f3_q[1:0])
      2'd0:    base_be = 4'b0001;
      2'd1:    base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  end

`ifdef RISC_LSU_MISALIGNED_SPLIT_EN
  logic            split_q;
  logic [XLEN-1:0] cap_q;
  logic [7:0]      be_full;

  assign err_in   = illegal_in;
  assign split_in = !illegal_in && cross_in;
  assign be_full  = {4'b0000, base_be} << off;
  assign last_beat = ((state == S_BEAT0) && !split_q) || (state == S_BEAT1);

  // BEAT1 joins the low lanes of this beat with the captured beat0 upper lanes
  always_comb begin
    if (state == S_BEAT1)
      load_shift = (mem_rdata << (6'd32 - {1'b0, off, 3'b000})) |
                   (cap_q >> {off, 3'b000});
    else
      load_shift = mem_rdata >> {off, 3'b000};
  end

  // Split bookkeeping and beat0 upper-lane capture for crossing loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q <= 1'b0;
      cap_q   <= '0;
    end else begin
      if (state == S_IDLE && req_valid)
        split_q <= split_in;
      if (state == S_BEAT0 && mem_ready && split_q && !we_q)
        cap_q <= mem_rdata;
    end
  end
`else
  assign err_in    = illegal_in || cross_in;
  assign split_in  = 1'b0;
  assign last_beat = (state == S_BEAT0);
  assign load_shift = mem_rdata >> {off, 3'b000};
`endif

  // Sign/zero extension of the lane-aligned load value
  always_comb begin
    case (f3_q)
      3'd0:    load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'd1:    load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'd4:    load_ext = {24'd0, load_shift[7:0]};
      3'd5:    load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  // State register; reset abandons any beat in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and bus outputs; bus fields are zero outside a beat
  always_comb begin
    state_nx  = state;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (req_valid)
          state_nx = err_in ? S_RESP : S_BEAT0;
      end
      S_BEAT0: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr;
        mem_be    = base_be << off;
        if (we_q)
          mem_wdata = wdata_q << {off, 3'b000};
        if (mem_ready)
          state_nx = last_beat ? S_RESP : S_BEAT1;
      end
`ifdef RISC_LSU_MISALIGNED_SPLIT_EN
      S_BEAT1: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_addr + ADDR_W'(4);
        mem_be    = be_full[7:4];
        if (we_q)
          mem_wdata = wdata_q >> (6'd32 - {1'b0, off, 3'b000});
        if (mem_ready)
          state_nx = S_RESP;
      end
`endif
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture and response data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= err_in;
        if (err_in)
          rdata_q <= '0;
      end
      if (last_beat && mem_ready)
        rdata_q <= we_q ? '0 : load_ext;
    end
  end

  assign req_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = (state == S_RESP) && err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_risc_lsu.sv
// Directed bench for risc_lsu. Inputs are driven and outputs sampled on the
// falling edge; the DUT updates on the rising edge.
module tb_risc_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  risc_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle (accepted at the next rising edge when
  // the DUT is idle), returning at the falling edge of the following cycle.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_mem_be",    32'(mem_be),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);

    // 1. LW 0x100
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    chk("lw_mem_valid", 32'(mem_valid), 32'd1);
    chk("lw_mem_be",    32'(mem_be),    32'hF);
    chk("lw_mem_addr",  mem_addr,       32'h100);
    chk("lw_mem_we",    32'(mem_we),    32'd0);
    chk("lw_busy",      32'(busy),      32'd1);
    chk("lw_no_rsp_n1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lw_rsp_rdata", rsp_rdata,      32'hDEADBEEF);
    chk("lw_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    chk("lw_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("lw_rdata_hold", rsp_rdata,     32'hDEADBEEF);
    chk("lw_idle",      32'(busy),      32'd0);

    // 2. LB / LBU at 0x103
    mem_rdata = 32'h80FFFFFF;
    issue(1'b0, 3'd0, 32'h0000_0103, 32'd0);
    chk("lb_mem_be",   32'(mem_be), 32'h8);
    chk("lb_mem_addr", mem_addr,    32'h100);
    @(negedge clk);
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
    @(negedge clk);
    issue(1'b0, 3'd4, 32'h0000_0103, 32'd0);
    @(negedge clk);
    chk("lbu_rsp_rdata", rsp_rdata, 32'h00000080);
    @(negedge clk);

    // LH in-word at offset 1 (not split)
    mem_rdata = 32'h00F00F00;
    issue(1'b0, 3'd1, 32'h0000_0101, 32'd0);
    chk("lh1_mem_be", 32'(mem_be), 32'h6);
    @(negedge clk);
    chk("lh1_rsp_rdata", rsp_rdata, 32'hFFFFF00F);
    chk("lh1_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    issue(1'b0, 3'd5, 32'h0000_0101, 32'd0);
    @(negedge clk);
    chk("lhu1_rsp_rdata", rsp_rdata, 32'h0000F00F);
    @(negedge clk);

    // 3. SH 0x202 and SB 0x301
    issue(1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234);
    chk("sh_mem_addr",  mem_addr,       32'h200);
    chk("sh_mem_be",    32'(mem_be),    32'hC);
    chk("sh_mem_wdata", mem_wdata,      32'h12340000);
    chk("sh_mem_we",    32'(mem_we),    32'd1);
    @(negedge clk);
    chk("sh_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sh_rsp_rdata", rsp_rdata,      32'd0);
    chk("sh_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    issue(1'b1, 3'd0, 32'h0000_0301, 32'hCAFE_00AB);
    chk("sb_mem_be",    32'(mem_be), 32'h2);
    chk("sb_mem_wdata", mem_wdata,   32'hFE00AB00);
    chk("sb_mem_addr",  mem_addr,    32'h300);
    @(negedge clk);
    @(negedge clk);

    // 4. Three stall cycles on LW 0x100
    mem_ready = 1'b0;
    mem_rdata = 32'h01234567;
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_mem_valid", 32'(mem_valid), 32'd1);
      chk("stall_mem_addr",  mem_addr,       32'h100);
      chk("stall_mem_be",    32'(mem_be),    32'hF);
      chk("stall_busy",      32'(busy),      32'd1);
      chk("stall_no_rsp",    32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    chk("stall_release_valid", 32'(mem_valid), 32'd1);
    chk("stall_release_norsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_rdata", rsp_rdata,      32'h01234567);
    @(negedge clk);

    // Reset during a stalled beat
    mem_ready = 1'b0;
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_ready",     32'(req_ready), 32'd0);
    chk("mid_rst_rdata",     rsp_rdata,      32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp",   32'(rsp_valid), 32'd0);
      chk("post_rst_no_valid", 32'(mem_valid), 32'd0);
    end

    // 5. Word-crossing LW at 0xFFFFFFFE
`ifdef RISC_LSU_MISALIGNED_SPLIT_EN
    mem_rdata = 32'hAABB1111;
    issue(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0);
    chk("split_b0_addr",  mem_addr,       32'hFFFFFFFC);
    chk("split_b0_be",    32'(mem_be),    32'hC);
    chk("split_b0_valid", 32'(mem_valid), 32'd1);
    mem_rdata = 32'h2222CCDD;
    @(negedge clk);
    chk("split_b1_addr",  mem_addr,       32'h00000000);
    chk("split_b1_be",    32'(mem_be),    32'h3);
    chk("split_b1_norsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("split_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("split_rsp_rdata", rsp_rdata,      32'hCCDDAABB);
    chk("split_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    issue(1'b1, 3'd1, 32'h0000_0403, 32'h0000_5678);
    chk("split_sh_b0_be",    32'(mem_be), 32'h8);
    chk("split_sh_b0_wdata", mem_wdata,   32'h78000000);
    @(negedge clk);
    chk("split_sh_b1_addr",  mem_addr,    32'h404);
    chk("split_sh_b1_be",    32'(mem_be), 32'h1);
    chk("split_sh_b1_wdata", mem_wdata,   32'h00000056);
    @(negedge clk);
    chk("split_sh_rsp", 32'(rsp_valid), 32'd1);
    @(negedge clk);
`else
    mem_rdata = 32'hAABB1111;
    issue(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0);
    chk("cross_lw_no_valid", 32'(mem_valid), 32'd0);
    chk("cross_lw_rsp",      32'(rsp_valid), 32'd1);
    chk("cross_lw_err",      32'(rsp_err),   32'd1);
    chk("cross_lw_rdata",    rsp_rdata,      32'd0);
    @(negedge clk);
    issue(1'b1, 3'd1, 32'h0000_0403, 32'h0000_5678);
    chk("cross_sh_no_valid", 32'(mem_valid), 32'd0);
    chk("cross_sh_err",      32'(rsp_err),   32'd1);
    @(negedge clk);
`endif

    // 6. Illegal load funct3, then LW accepted the cycle after RESP
    mem_rdata = 32'h5A5A_0F0F;
    issue(1'b0, 3'd3, 32'h0000_0100, 32'd0);
    chk("ill_no_valid",  32'(mem_valid), 32'd0);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_err",   32'(rsp_err),   32'd1);
    chk("ill_ready_low", 32'(req_ready), 32'd0);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0100;
    @(negedge clk);
    chk("ill_next_ready", 32'(req_ready), 32'd1);
    chk("ill_rsp_pulse",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ill_next_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    chk("ill_next_rsp",   32'(rsp_valid), 32'd1);
    chk("ill_next_rdata", rsp_rdata,      32'h5A5A0F0F);
    chk("ill_next_err",   32'(rsp_err),   32'd0);
    @(negedge clk);

    // Illegal store funct3
    issue(1'b1, 3'd3, 32'h0000_0200, 32'h1);
    chk("ill_st_no_valid", 32'(mem_valid), 32'd0);
    chk("ill_st_err",      32'(rsp_err),   32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
